locker_fsm: RTL and testbench

Code-entry controller for the locker design, sitting directly upstream of the `D_EN` gated-latch stage that holds the lock state. It collects keypad digits, compares the entered sequence against a parameterised password, and counts failed attempts with a timed lockout. It drives the latch's data and enable inputs with a setup-safe, one-cycle enable pulse.

---
 rtl/locker_pkg.sv | 24 ++
 rtl/locker_timer.sv | 35 +++
 rtl/locker_fsm.sv | 155 +++++++++++++++
 tb/tb_locker_fsm.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/locker_pkg.sv
// Shared types and widths for the locker code-entry controller.
// The helper gives the packed width of a DIGITS-long nibble password.
package locker_pkg;

  localparam int unsigned KEY_W      = 4;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned TRY_W      = 3;
  localparam int unsigned MAX_DIGITS = 7;
  localparam int unsigned PW_MAX     = MAX_DIGITS * KEY_W;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StEntry,
    StCheck,
    StOpen,
    StLockout
  } state_e;

  function automatic int unsigned pw_width(input int unsigned digits);
    return digits * KEY_W;
  endfunction

endpackage

// File: rtl/locker_timer.sv
// Loadable down-counter: start loads the period, done is high in the last
// cycle of the period, so the period spans exactly LOCKOUT_CYCLES cycles after start.
module locker_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = $clog2(LOCKOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= CW'(LOCKOUT_CYCLES - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/locker_fsm.sv
// Keypad code-entry controller driving the D_EN lock latch with a one-cycle
// enable pulse; counts failed attempts and enforces a timed lockout.
module locker_fsm
  import locker_pkg::*;
#(
  parameter int unsigned       DIGITS         = 4,
  parameter logic [PW_MAX-1:0] PASSWORD       = 28'h0002418,
  parameter int unsigned       MAX_TRIES      = 3,
  parameter int unsigned       LOCKOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_enter,
  input  logic             key_clear,
  input  logic             lock_req,
  output logic             latch_c,
  output logic             latch_d,
  output logic             unlocked,
  output logic             alarm,
  output logic [CNT_W-1:0] digit_cnt,
  output logic [TRY_W-1:0] tries_left
);

  localparam int unsigned      PW       = pw_width(DIGITS);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);
  localparam logic [TRY_W-1:0] TRIES_C  = TRY_W'(MAX_TRIES);

  state_e           state_q;
  logic [PW-1:0]    entry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TRY_W-1:0] tries_q;
  logic             ovf_q;
  logic             pend_q;
  logic             latch_c_q;
  logic             latch_d_q;
  logic             unlocked_q;
  logic             alarm_q;

  logic match;
  logic last_try;
  logic timer_start;
  logic timer_done;

  assign match       = (cnt_q == DIGITS_C) && !ovf_q && (entry_q == PASSWORD[PW-1:0]);
  assign last_try    = (tries_q <= TRY_W'(1));
  assign timer_start = (state_q == StCheck) && !match && last_try;

  locker_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(timer_start),
    .done (timer_done)
  );

  // pend_q marks a latch_c pulse owed one cycle after latch_d changed, so the
  // latch always sees a settled D before its enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      entry_q    <= '0;
      cnt_q      <= '0;
      tries_q    <= TRIES_C;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      latch_c_q  <= 1'b0;
      latch_d_q  <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      latch_c_q <= 1'b0;
      case (state_q)
        StInit: begin
          latch_d_q <= 1'b0;
          latch_c_q <= 1'b1;
          state_q   <= StIdle;
        end
        StIdle, StEntry: begin
          if (key_clear) begin
            entry_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
          end else if (key_enter) begin
            if (cnt_q != '0) begin
              state_q <= StCheck;
            end
          end else if (key_valid) begin
            entry_q <= PW'({entry_q, key_code});
            if (cnt_q == DIGITS_C) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            state_q <= StEntry;
          end
        end
        StCheck: begin
          entry_q <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          if (match) begin
            state_q    <= StOpen;
            tries_q    <= TRIES_C;
            latch_d_q  <= 1'b1;
            unlocked_q <= 1'b1;
            pend_q     <= 1'b1;
          end else begin
            tries_q <= tries_q - TRY_W'(1);
            if (last_try) begin
              state_q <= StLockout;
              alarm_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StOpen: begin
          // The same pend_q serves the open pulse and the relock pulse;
          // unlocked_q tells which one is being issued.
          if (pend_q) begin
            latch_c_q <= 1'b1;
            pend_q    <= 1'b0;
            if (!unlocked_q) begin
              state_q <= StIdle;
            end
          end else if (lock_req) begin
            latch_d_q  <= 1'b0;
            unlocked_q <= 1'b0;
            pend_q     <= 1'b1;
          end
        end
        StLockout: begin
          if (timer_done) begin
            state_q <= StIdle;
            alarm_q <= 1'b0;
            tries_q <= TRIES_C;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign latch_c    = latch_c_q;
  assign latch_d    = latch_d_q;
  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign digit_cnt  = cnt_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_locker_fsm.sv
// Self-checking bench for locker_fsm: directed scenarios plus randomized
// attempts checked against a sequence-level model of the locker rules.
module tb_locker_fsm;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned LOCKOUT   = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       lock_req = 1'b0;
  logic       latch_c;
  logic       latch_d;
  logic       unlocked;
  logic       alarm;
  logic [2:0] digit_cnt;
  logic [2:0] tries_left;

  int checks = 0;
  int failures = 0;
  int m_tries = MAX_TRIES;
  int pw[4] = '{2, 4, 1, 8};

  logic lc_prev = 1'b0;
  logic ld_prev = 1'b0;

  always #5 clk = ~clk;

  locker_fsm #(
    .DIGITS        (DIGITS),
    .PASSWORD      (28'h0002418),
    .MAX_TRIES     (MAX_TRIES),
    .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .lock_req  (lock_req),
    .latch_c   (latch_c),
    .latch_d   (latch_d),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .digit_cnt (digit_cnt),
    .tries_left(tries_left)
  );

  // Latch handshake: every enable pulse is one cycle wide, with D already settled.
  always @(negedge clk) begin
    if (rst_n && latch_c === 1'b1) begin
      checks++;
      if (lc_prev !== 1'b0 || latch_d !== ld_prev) begin
        failures++;
        $display("FAIL latch_handshake: c_prev=%b d=%b d_prev=%b, required c_prev=0 and d stable",
                 lc_prev, latch_d, ld_prev);
      end
    end
    lc_prev = latch_c;
    ld_prev = latch_d;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  function automatic bit is_match(input int s[$]);
    if (s.size() != DIGITS) return 1'b0;
    for (int i = 0; i < DIGITS; i++) if (s[i] != pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Ticks through the lockout while hammering keys; returns alarm-high cycle count.
  task automatic ride_lockout(output int n);
    n = 0;
    while (alarm === 1'b1 && n < 2 * LOCKOUT) begin
      n++;
      key_valid = 1'b1;
      key_code  = 4'($urandom_range(0, 15));
      key_enter = ($urandom_range(0, 3) == 0);
      tick();
      key_valid = 1'b0;
      key_enter = 1'b0;
      if (digit_cnt !== 3'd0) begin
        checks++;
        failures++;
        $display("FAIL lockout_keys_ignored: digit_cnt=%0d required 0", digit_cnt);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({latch_c, latch_d, unlocked, alarm, digit_cnt, tries_left} !== {4'b0000, 3'd0, 3'd3}) begin
      failures++;
      $display("FAIL reset_values: c=%b d=%b u=%b a=%b cnt=%0d tries=%0d required 0 0 0 0 0 3",
               latch_c, latch_d, unlocked, alarm, digit_cnt, tries_left);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (latch_c !== 1'b1 || latch_d !== 1'b0 || unlocked !== 1'b0) begin
      failures++;
      $display("FAIL init_pulse: c=%b d=%b u=%b required 1 0 0", latch_c, latch_d, unlocked);
    end
    n = 0;
    repeat (4) begin
      tick();
      if (latch_c === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL init_single_pulse: extra pulses=%0d required 0", n);
    end
    m_tries = MAX_TRIES;
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 4; i++) begin
      press(4'(pw[i]));
      checks++;
      if (digit_cnt !== 3'(i + 1)) begin
        failures++;
        $display("FAIL unlock_digit_cnt: got %0d required %0d", digit_cnt, i + 1);
      end
    end
    enter();
    checks++;
    if (unlocked !== 1'b0) begin
      failures++;
      $display("FAIL unlock_check_cycle: unlocked=%b required 0", unlocked);
    end
    tick();
    checks++;
    if (unlocked !== 1'b1 || latch_d !== 1'b1 || latch_c !== 1'b0 || tries_left !== 3'd3) begin
      failures++;
      $display("FAIL unlock_t2: u=%b d=%b c=%b tries=%0d required 1 1 0 3",
               unlocked, latch_d, latch_c, tries_left);
    end
    tick();
    checks++;
    if (latch_c !== 1'b1) begin
      failures++;
      $display("FAIL unlock_pulse_t3: latch_c=%b required 1", latch_c);
    end
    tick();
    checks++;
    if (latch_c !== 1'b0) begin
      failures++;
      $display("FAIL unlock_pulse_end: latch_c=%b required 0", latch_c);
    end
    press(4'd5);
    checks++;
    if (digit_cnt !== 3'd0 || unlocked !== 1'b1) begin
      failures++;
      $display("FAIL open_keys_ignored: cnt=%0d u=%b required 0 1", digit_cnt, unlocked);
    end
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    checks++;
    if (latch_d !== 1'b0 || unlocked !== 1'b0 || latch_c !== 1'b0) begin
      failures++;
      $display("FAIL relock_t1: d=%b u=%b c=%b required 0 0 0", latch_d, unlocked, latch_c);
    end
    tick();
    checks++;
    if (latch_c !== 1'b1 || latch_d !== 1'b0) begin
      failures++;
      $display("FAIL relock_pulse: c=%b d=%b required 1 0", latch_c, latch_d);
    end
    tick();
    m_tries = MAX_TRIES;
  endtask

  task automatic test_lockout();
    int bad[4] = '{2, 4, 1, 9};
    int n;
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < 4; i++) press(4'(bad[i]));
      enter();
      tick();
      m_tries--;
      checks++;
      if (tries_left !== 3'(m_tries) || alarm !== (m_tries == 0)) begin
        failures++;
        $display("FAIL lockout_tries: tries=%0d alarm=%b required %0d %b",
                 tries_left, alarm, m_tries, (m_tries == 0));
      end
    end
    ride_lockout(n);
    checks++;
    if (n != LOCKOUT) begin
      failures++;
      $display("FAIL lockout_duration: alarm cycles=%0d required %0d", n, LOCKOUT);
    end
    m_tries = MAX_TRIES;
    checks++;
    if (tries_left !== 3'd3 || alarm !== 1'b0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL lockout_exit: tries=%0d alarm=%b cnt=%0d required 3 0 0",
               tries_left, alarm, digit_cnt);
    end
  endtask

  task automatic test_overflow();
    int seq[5] = '{2, 4, 1, 8, 0};
    for (int i = 0; i < 5; i++) begin
      press(4'(seq[i]));
      checks++;
      if (digit_cnt !== 3'((i + 1 > 4) ? 4 : i + 1)) begin
        failures++;
        $display("FAIL overflow_digit_cnt: got %0d required %0d", digit_cnt,
                 (i + 1 > 4) ? 4 : i + 1);
      end
    end
    enter();
    tick();
    m_tries--;
    checks++;
    if (tries_left !== 3'(m_tries) || unlocked !== 1'b0 || digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL overflow_attempt: tries=%0d u=%b cnt=%0d required %0d 0 0",
               tries_left, unlocked, digit_cnt, m_tries);
    end
  endtask

  task automatic test_clear_priority();
    press(4'd2);
    press(4'd4);
    press(4'd1);
    key_clear = 1'b1;
    key_enter = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd8;
    tick();
    key_clear = 1'b0;
    key_enter = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (digit_cnt !== 3'd0) begin
      failures++;
      $display("FAIL clear_priority_cnt: cnt=%0d required 0", digit_cnt);
    end
    tick();
    tick();
    checks++;
    if (tries_left !== 3'(m_tries) || unlocked !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_check: tries=%0d u=%b required %0d 0", tries_left, unlocked, m_tries);
    end
    enter();
    tick();
    tick();
    checks++;
    if (tries_left !== 3'(m_tries) || digit_cnt !== 3'd0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL empty_enter_ignored: tries=%0d cnt=%0d alarm=%b required %0d 0 0",
               tries_left, digit_cnt, alarm, m_tries);
    end
  endtask

  task automatic test_random();
    int  seq[$];
    int  kind;
    int  n;
    bit  exp_match;
    for (int a = 0; a < 30; a++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) press(4'($urandom_range(0, 15)));
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        checks++;
        if (digit_cnt !== 3'd0) begin
          failures++;
          $display("FAIL rand_clear: cnt=%0d required 0", digit_cnt);
        end
      end
      seq.delete();
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        for (int i = 0; i < 4; i++) seq.push_back(pw[i]);
      end else if (kind == 1) begin
        for (int i = 0; i < 4; i++) seq.push_back(pw[i]);
        n = $urandom_range(0, 3);
        seq[n] = (seq[n] + $urandom_range(1, 15)) % 16;
      end else begin
        repeat ($urandom_range(1, 6)) seq.push_back($urandom_range(0, 15));
      end
      for (int i = 0; i < seq.size(); i++) begin
        press(4'(seq[i]));
        checks++;
        if (digit_cnt !== 3'((i + 1 > DIGITS) ? DIGITS : i + 1)) begin
          failures++;
          $display("FAIL rand_digit_cnt: got %0d required %0d", digit_cnt,
                   (i + 1 > DIGITS) ? DIGITS : i + 1);
        end
        repeat ($urandom_range(0, 2)) tick();
      end
      exp_match = is_match(seq);
      enter();
      tick();
      if (exp_match) m_tries = MAX_TRIES;
      else m_tries--;
      checks++;
      if (unlocked !== exp_match || tries_left !== 3'(m_tries)) begin
        failures++;
        $display("FAIL rand_attempt %0d: unlocked=%b tries=%0d required %b %0d",
                 a, unlocked, tries_left, exp_match, m_tries);
      end
      if (exp_match) begin
        tick();
        tick();
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
        tick();
        tick();
        checks++;
        if (unlocked !== 1'b0 || latch_d !== 1'b0) begin
          failures++;
          $display("FAIL rand_relock: u=%b d=%b required 0 0", unlocked, latch_d);
        end
      end else if (m_tries == 0) begin
        ride_lockout(n);
        m_tries = MAX_TRIES;
        checks++;
        if (n != LOCKOUT || tries_left !== 3'(m_tries)) begin
          failures++;
          $display("FAIL rand_lockout: alarm cycles=%0d tries=%0d required %0d %0d",
                   n, tries_left, LOCKOUT, m_tries);
        end
      end
    end
  endtask

  task automatic test_reset_in_open();
    for (int i = 0; i < 4; i++) press(4'(pw[i]));
    enter();
    tick();
    tick();
    tick();
    checks++;
    if (unlocked !== 1'b1) begin
      failures++;
      $display("FAIL reset_open_setup: unlocked=%b required 1", unlocked);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({latch_c, latch_d, unlocked, alarm, digit_cnt, tries_left} !== {4'b0000, 3'd0, 3'd3}) begin
      failures++;
      $display("FAIL async_reset: c=%b d=%b u=%b a=%b cnt=%0d tries=%0d required 0 0 0 0 0 3",
               latch_c, latch_d, unlocked, alarm, digit_cnt, tries_left);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (latch_c !== 1'b1 || latch_d !== 1'b0) begin
      failures++;
      $display("FAIL reinit_pulse: c=%b d=%b required 1 0", latch_c, latch_d);
    end
    tick();
    checks++;
    if (latch_c !== 1'b0 || unlocked !== 1'b0) begin
      failures++;
      $display("FAIL reinit_end: c=%b u=%b required 0 0", latch_c, unlocked);
    end
    m_tries = MAX_TRIES;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_overflow();
    test_clear_priority();
    test_random();
    test_reset_in_open();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
